// File: rtl/arp_pkg.sv
// Shared ARP constants, field offsets, state encoding and byte helpers
// for the transmit builder and the receive-side checker.
package arp_pkg;

    localparam logic [15:0] ARP_REQUEST_CODE   = 16'h0001;
    localparam logic [15:0] ARP_REPLY_CODE     = 16'h0002;
    localparam logic [15:0] ARP_HTYPE_DEFAULT  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_DEFAULT  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN           = 8'd6;
    localparam logic [7:0]  ARP_PLEN           = 8'd4;
    localparam logic [47:0] ARP_BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    localparam int ARP_HDR_BYTES = 28;
    localparam int OP_OFF  = 6;
    localparam int SHA_OFF = 8;
    localparam int SPA_OFF = 14;
    localparam int THA_OFF = 18;
    localparam int TPA_OFF = 24;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WAIT = 4'b0010,
        S_SEND = 4'b0100,
        S_END  = 4'b1000
    } arp_tx_state_e;

    typedef struct packed {
        logic [15:0] op;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

    // Byte k (0 = most significant) of an nbytes-wide field held in f.
    function automatic logic [7:0] field_byte(
        input logic [47:0] f,
        input int          nbytes,
        input int          k
    );
        logic [47:0] s;
        s = f >> (8 * (nbytes - 1 - k));
        return s[7:0];
    endfunction

endpackage

// File: rtl/arp_tx_if.sv
// MAC-side transmit bundle: slot request/grant, destination MAC
// and the payload byte stream.
interface arp_tx_if;
    import arp_pkg::*;

    logic        arp_tx_req;
    logic        arp_tx_ack;
    logic [47:0] arp_tx_dst_mac;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_valid;
    logic        arp_tx_end;

    modport master (
        output arp_tx_req,
        output arp_tx_dst_mac,
        output arp_tx_data,
        output arp_tx_valid,
        output arp_tx_end,
        input  arp_tx_ack
    );

    modport slave (
        input  arp_tx_req,
        input  arp_tx_dst_mac,
        input  arp_tx_data,
        input  arp_tx_valid,
        input  arp_tx_end,
        output arp_tx_ack
    );

endinterface

// File: rtl/arp_tx_byte_mux.sv
// Combinational ARP payload byte select: offset -> byte of the
// fixed header prefix or of a latched field, zero beyond the header.
module arp_tx_byte_mux
    import arp_pkg::*;
#(
    parameter int          IDX_W = 6,
    parameter logic [15:0] HTYPE = ARP_HTYPE_DEFAULT,
    parameter logic [15:0] PTYPE = ARP_PTYPE_DEFAULT
) (
    input  arp_fields_t      fields,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    logic [47:0] prefix;

    assign prefix = {HTYPE, PTYPE, ARP_HLEN, ARP_PLEN};

    always_comb begin
        int i;
        i    = int'(idx);
        data = 8'h00;
        unique case (1'b1)
            (i < OP_OFF):
                data = field_byte(prefix, 6, i);
            (i >= OP_OFF && i < SHA_OFF):
                data = field_byte({32'h0, fields.op}, 2, i - OP_OFF);
            (i >= SHA_OFF && i < SPA_OFF):
                data = field_byte(fields.sha, 6, i - SHA_OFF);
            (i >= SPA_OFF && i < THA_OFF):
                data = field_byte({16'h0, fields.spa}, 4, i - SPA_OFF);
            (i >= THA_OFF && i < TPA_OFF):
                data = field_byte(fields.tha, 6, i - THA_OFF);
            (i >= TPA_OFF && i < ARP_HDR_BYTES):
                data = field_byte({16'h0, fields.tpa}, 4, i - TPA_OFF);
            default:
                data = 8'h00;
        endcase
    end

endmodule

// File: rtl/arp_tx.sv
// ARP transmit builder: captures reply/request jobs, waits for the MAC
// slot and streams a zero-padded ARP payload with its destination MAC.
module arp_tx
    import arp_pkg::*;
#(
    parameter int          FRAME_BYTES = 46,
    parameter logic [15:0] ARP_HTYPE   = ARP_HTYPE_DEFAULT,
    parameter logic [15:0] ARP_PTYPE   = ARP_PTYPE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   local_ip_addr,
    input  logic [47:0]   local_mac_addr,
    input  logic          arp_reply_req,
    input  logic [31:0]   arp_rec_source_ip_addr,
    input  logic [47:0]   arp_rec_source_mac_addr,
    input  logic          arp_request_req,
    input  logic [31:0]   arp_request_ip_addr,
    output logic          arp_reply_ack,
    output logic          arp_request_ack,
    output logic          arp_tx_busy,
    arp_tx_if.master      tx
);

    localparam int CNT_W = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

    arp_tx_state_e    state;
    arp_fields_t      fields;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sel;
    logic [7:0]       mux_byte;

    // Registered data runs one step ahead of the counter: pick the
    // byte that becomes visible after this edge.
    always_comb begin
        sel = '0;
        if (state == S_SEND)
            sel = cnt + CNT_W'(1);
    end

    arp_tx_byte_mux #(
        .IDX_W (CNT_W),
        .HTYPE (ARP_HTYPE),
        .PTYPE (ARP_PTYPE)
    ) u_mux (
        .fields (fields),
        .idx    (sel),
        .data   (mux_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            fields            <= '0;
            cnt               <= '0;
            arp_reply_ack     <= 1'b0;
            arp_request_ack   <= 1'b0;
            arp_tx_busy       <= 1'b0;
            tx.arp_tx_req     <= 1'b0;
            tx.arp_tx_dst_mac <= '0;
            tx.arp_tx_data    <= '0;
            tx.arp_tx_valid   <= 1'b0;
            tx.arp_tx_end     <= 1'b0;
        end else begin
            arp_reply_ack   <= 1'b0;
            arp_request_ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arp_reply_req) begin
                        fields.op         <= ARP_REPLY_CODE;
                        fields.sha        <= local_mac_addr;
                        fields.spa        <= local_ip_addr;
                        fields.tha        <= arp_rec_source_mac_addr;
                        fields.tpa        <= arp_rec_source_ip_addr;
                        tx.arp_tx_dst_mac <= arp_rec_source_mac_addr;
                        arp_reply_ack     <= 1'b1;
                        tx.arp_tx_req     <= 1'b1;
                        arp_tx_busy       <= 1'b1;
                        state             <= S_WAIT;
                    end else if (arp_request_req) begin
                        fields.op         <= ARP_REQUEST_CODE;
                        fields.sha        <= local_mac_addr;
                        fields.spa        <= local_ip_addr;
                        fields.tha        <= '0;
                        fields.tpa        <= arp_request_ip_addr;
                        tx.arp_tx_dst_mac <= ARP_BCAST_MAC;
                        arp_request_ack   <= 1'b1;
                        tx.arp_tx_req     <= 1'b1;
                        arp_tx_busy       <= 1'b1;
                        state             <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx.arp_tx_ack) begin
                        tx.arp_tx_req   <= 1'b0;
                        tx.arp_tx_valid <= 1'b1;
                        tx.arp_tx_data  <= mux_byte;
                        tx.arp_tx_end   <= 1'b0;
                        cnt             <= '0;
                        state           <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt == LAST) begin
                        tx.arp_tx_valid <= 1'b0;
                        tx.arp_tx_data  <= '0;
                        tx.arp_tx_end   <= 1'b0;
                        state           <= S_END;
                    end else begin
                        cnt            <= sel;
                        tx.arp_tx_data <= mux_byte;
                        tx.arp_tx_end  <= (sel == LAST);
                    end
                end
                S_END: begin
                    tx.arp_tx_dst_mac <= '0;
                    arp_tx_busy       <= 1'b0;
                    cnt               <= '0;
                    state             <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
